// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared FPU definitions: the arbiter state encoding,
//                single-precision field positions and the requester limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

   // Arbiter state: idle/arbitrate, register product, present response.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int FP_W     = 32;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int SIGN_BIT = 31;
   localparam int MAX_REQ  = 8;

endpackage
`default_nettype wire

// File: rtl/fpu_mult.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_mult
//  Description : Combinational single-precision multiplier core. It always
//                assumes an implicit leading one, adds biased exponents
//                modulo 256 and truncates the significand. Zero, subnormal,
//                NaN/Inf and overflow are not treated specially.
//  Ports       : a, b  - IEEE 754 operands
//                p     - raw product
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_mult
   import fpu_pkg::*;
(
   input  logic [FP_W-1:0] a,
   input  logic [FP_W-1:0] b,
   output logic [FP_W-1:0] p
);

   logic [47:0] w_prod;
   logic [24:0] w_hi;
   logic        w_norm;
   logic [22:0] w_mant;
   logic [7:0]  w_exp;

   always_comb begin
      w_prod = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
      // Keep the top 25 product bits: [24] is the carry into 2.x range.
      w_hi   = 25'(w_prod >> 23);
      w_norm = w_hi[24];
      w_mant = w_norm ? w_hi[23:1] : w_hi[22:0];
      w_exp  = a[EXP_MSB:EXP_LSB] + b[EXP_MSB:EXP_LSB] - 8'd127
               + {7'b0, w_norm};
      p      = {a[SIGN_BIT] ^ b[SIGN_BIT], w_exp, w_mant};
   end

endmodule
`default_nettype wire

// File: rtl/fpu_mult_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_mult_arb
//  Description : Round-robin arbiter sharing one fpu_mult among NUM_REQ
//                requesters. One transaction in flight: accept (IDLE),
//                register product (CALC), hold response until taken (RESP).
//  Ports       : clk, rst            - clock, async active-high reset
//                req_valid/req_ready - per-requester request handshake
//                req_a, req_b        - packed operands, 32 bits per requester
//                rsp_valid/rsp_ready - per-requester response handshake
//                rsp_data            - shared result bus (0 outside RESP)
//                busy                - high when not IDLE
//  Options     : FPU_MULT_ZERO_DETECT_EN - flush zero/subnormal operands to a
//                signed zero result.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_mult_arb
   import fpu_pkg::*;
#(
   parameter int NUM_REQ = 2
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*FP_W-1:0] req_a,
   input  logic [NUM_REQ*FP_W-1:0] req_b,
   output logic [NUM_REQ-1:0]      rsp_valid,
   input  logic [NUM_REQ-1:0]      rsp_ready,
   output logic [FP_W-1:0]         rsp_data,
   output logic                    busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] C_ONE = NUM_REQ'(1);
   localparam logic [IDX_W-1:0]   C_LAST = IDX_W'(NUM_REQ - 1);

   state_t            r_state;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_owner;
   logic [FP_W-1:0]   r_a;
   logic [FP_W-1:0]   r_b;
   logic [FP_W-1:0]   r_res;

   logic              w_found;
   logic [IDX_W-1:0]  w_grant;
   logic [FP_W-1:0]   w_sel_a;
   logic [FP_W-1:0]   w_sel_b;
   logic [FP_W-1:0]   w_mult;
   logic [IDX_W-1:0]  w_ptr_next;

   // First valid index scanning upward from ptr with wrap-around.
   // Returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(
      input logic [NUM_REQ-1:0] valid,
      input logic [IDX_W-1:0]   ptr
   );
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      int               j;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         cand = IDX_W'(j);
         if (!found && valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      {w_found, w_grant} = rr_pick(req_valid, r_ptr);
   end

   // Operand mux for the current winner.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDX_W'(i) == w_grant) begin
            w_sel_a = req_a[i*FP_W +: FP_W];
            w_sel_b = req_b[i*FP_W +: FP_W];
         end
      end
   end

   assign w_ptr_next = (r_owner == C_LAST) ? '0 : r_owner + 1'b1;

   fpu_mult u_fpu_mult (
      .a (r_a),
      .b (r_b),
      .p (w_mult)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_a     <= w_sel_a;
                  r_b     <= w_sel_b;
                  r_owner <= w_grant;
                  r_state <= CALC;
               end
            end
            CALC: begin
`ifdef FPU_MULT_ZERO_DETECT_EN
               // A zero exponent means zero or subnormal: flush to signed 0.
               if ((r_a[EXP_MSB:EXP_LSB] == '0) || (r_b[EXP_MSB:EXP_LSB] == '0))
                  r_res <= {r_a[SIGN_BIT] ^ r_b[SIGN_BIT], {(FP_W-1){1'b0}}};
               else
                  r_res <= w_mult;
`else
               r_res <= w_mult;
`endif
               r_state <= RESP;
            end
            RESP: begin
               if (rsp_ready[r_owner]) begin
                  r_ptr   <= w_ptr_next;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // req_ready is gated by rst so it reads zero while reset is held.
   always_comb begin
      req_ready = '0;
      if (!rst && (r_state == IDLE) && w_found)
         req_ready = C_ONE << w_grant;
   end

   assign rsp_valid = (r_state == RESP) ? (C_ONE << r_owner) : '0;
   assign rsp_data  = (r_state == RESP) ? r_res : '0;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_mult_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_mult_arb
//  Description : Directed self-checking bench for fpu_mult_arb (NUM_REQ=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_mult_arb;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

`ifdef FPU_MULT_ZERO_DETECT_EN
   localparam logic [31:0] c_zero_pos = 32'h0000_0000;
`else
   localparam logic [31:0] c_zero_pos = 32'h0080_0000;
`endif

   fpu_mult_arb #(.NUM_REQ(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 2 time units after the rising edge; checks happen 1 later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
      req_a = '0; req_b = '0;
      tick();
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_data, busy} !== 37'b0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h busy=%b, want all zero",
                  req_ready, rsp_valid, rsp_data, busy);
      end
      rst = 1'b0; req_valid = 2'b00;
   endtask

   task automatic test_basic();
      do_reset();
      req_valid = 2'b01; req_a[31:0] = 32'h3FC0_0000; req_b[31:0] = 32'h4000_0000;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL basic_accept: got %b want 01", req_ready);
      end
      tick(); req_valid = 2'b00; #1;
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
         errors++; $display("FAIL basic_calc: got busy=%b vld=%b want 1/00", busy, rsp_valid);
      end
      tick(); rsp_ready = 2'b01; #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'h4040_0000) begin
         errors++; $display("FAIL basic_resp: got vld=%b data=%h want 01/40400000", rsp_valid, rsp_data);
      end
      tick(); #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
         errors++; $display("FAIL basic_idle: got busy=%b vld=%b data=%h want 0/00/0", busy, rsp_valid, rsp_data);
      end
   endtask

   // Follows test_basic directly, so ptr is 1 here.
   task automatic test_sign();
      req_valid = 2'b10; req_a[63:32] = 32'hBF80_0000; req_b[63:32] = 32'h4000_0000;
      rsp_ready = 2'b10;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++; $display("FAIL sign_accept: got %b want 10", req_ready);
      end
      tick(); req_valid = 2'b00;
      tick(); #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hC000_0000) begin
         errors++; $display("FAIL sign_resp: got vld=%b data=%h want 10/c0000000", rsp_valid, rsp_data);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_vld;
      logic [31:0] exp_data;
      do_reset();
      req_a = {32'hBF80_0000, 32'h3FC0_0000};
      req_b = {32'h4000_0000, 32'h4000_0000};
      req_valid = 2'b11; rsp_ready = 2'b11;
      for (int k = 0; k < 12; k++) begin
         if (k != 0) tick();
         #1;
         exp_rdy  = (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         exp_vld  = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         exp_data = (k % 3 != 2) ? 32'h0 :
                    (((k / 3) % 2 == 0) ? 32'h4040_0000 : 32'hC000_0000);
         checks++;
         if (req_ready !== exp_rdy || rsp_valid !== exp_vld || rsp_data !== exp_data) begin
            errors++;
            $display("FAIL rr_slot%0d: got rdy=%b vld=%b data=%h want rdy=%b vld=%b data=%h",
                     k, req_ready, rsp_valid, rsp_data, exp_rdy, exp_vld, exp_data);
         end
      end
      req_valid = 2'b00;
   endtask

   task automatic test_backpressure();
      do_reset();
      req_a = {32'hBF80_0000, 32'h3FC0_0000};
      req_b = {32'h4000_0000, 32'h4000_0000};
      req_valid = 2'b01;
      tick();
      req_valid = 2'b10; rsp_ready = 2'b00;
      tick();
      for (int k = 0; k < 5; k++) begin
         if (k != 0) tick();
         rsp_ready = (k % 2 == 0) ? 2'b00 : 2'b10;  // non-owner ready ignored
         #1;
         checks++;
         if (rsp_valid !== 2'b01 || rsp_data !== 32'h4040_0000 || req_ready !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold%0d: got vld=%b data=%h rdy=%b busy=%b want 01/40400000/00/1",
                     k, rsp_valid, rsp_data, req_ready, busy);
         end
      end
      tick(); rsp_ready = 2'b01;
      tick(); rsp_ready = 2'b11; #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++; $display("FAIL bp_next_grant: got %b want 10", req_ready);
      end
      tick(); req_valid = 2'b00;
      tick(); #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hC000_0000) begin
         errors++; $display("FAIL bp_second_resp: got vld=%b data=%h want 10/c0000000", rsp_valid, rsp_data);
      end
      tick();
   endtask

   task automatic test_zero_operand();
      do_reset();
      rsp_ready = 2'b11;
      req_valid = 2'b01; req_a[31:0] = 32'h8000_0000; req_b[31:0] = 32'h3F80_0000;
      tick(); req_valid = 2'b00;
      tick(); #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 32'h8000_0000) begin
         errors++; $display("FAIL zero_neg: got vld=%b data=%h want 01/80000000", rsp_valid, rsp_data);
      end
      tick();
      // ptr is now 1; requester 0 alone still wins after the wrap.
      req_valid = 2'b01; req_a[31:0] = 32'h0000_0000; req_b[31:0] = 32'h4000_0000;
      tick(); req_valid = 2'b00;
      tick(); #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== c_zero_pos) begin
         errors++; $display("FAIL zero_pos: got vld=%b data=%h want 01/%h", rsp_valid, rsp_data, c_zero_pos);
      end
      tick();
   endtask

   task automatic test_reset_in_calc();
      do_reset();
      rsp_ready = 2'b11;
      req_a = {32'hBF80_0000, 32'h3FC0_0000};
      req_b = {32'h4000_0000, 32'h4000_0000};
      req_valid = 2'b01;
      tick();
      req_valid = 2'b10;
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL rc_in_calc: got busy=%b want 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_data, busy} !== 37'b0) begin
         errors++;
         $display("FAIL rc_async_clear: got rdy=%b vld=%b data=%h busy=%b want all zero",
                  req_ready, rsp_valid, rsp_data, busy);
      end
      tick(); #1;
      checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         errors++; $display("FAIL rc_held: got vld=%b busy=%b want 00/0", rsp_valid, busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++; $display("FAIL rc_first_grant: got %b want 10", req_ready);
      end
      tick(); req_valid = 2'b00;
      tick(); #1;
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hC000_0000) begin
         errors++; $display("FAIL rc_resp: got vld=%b data=%h want 10/c0000000", rsp_valid, rsp_data);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_sign();
      test_round_robin();
      test_backpressure();
      test_zero_operand();
      test_reset_in_calc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
